// File: rtl/instr_encoder_if.sv
// Field-bundle stream into the encoder plus the instruction-memory write
// port and session status coming back out of it.
//
// Handshake: a bundle transfers on a rising clk edge where in_valid and
// in_ready are both 1. The source must hold the bundle (fields and in_last)
// stable while in_valid = 1 and in_ready = 0; in_ready never depends
// combinationally on in_valid.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    // Bundle source / memory sink side (boot source or testbench)
    modport master (
        output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7b5, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, done, err, count
    );

    // Encoder side
    modport slave (
        input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7b5, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, done, err, count
    );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: packs decoded RV32I fields into a
// 32-bit instruction word and writes the words sequentially into
// instruction memory, starting at word 0 for every session.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    instr_encoder_if.slave bus,
    output logic [1:0]     state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    state_t            state_q;
    logic              ready_q;
    logic              we_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;

    logic [31:0]       word_d;
    logic [6:0]        op_d;
    logic              is_shift;

    assign is_shift = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);

    // Pack the presented bundle into an instruction word; unused fields are 0
    always_comb begin
        op_d   = 7'b0000000;
        word_d = 32'h0000_0000;
        case (bus.in_fmt)
            3'd0: begin
                op_d   = 7'b0110011;
                word_d = {1'b0, bus.in_funct7b5, 5'b00000, bus.in_rs2, bus.in_rs1,
                          bus.in_funct3, bus.in_rd, op_d};
            end
            3'd1: begin
                op_d = 7'b0010011;
                if (is_shift) begin
                    word_d = {1'b0, bus.in_funct7b5, 5'b00000, bus.in_imm[4:0],
                              bus.in_rs1, bus.in_funct3, bus.in_rd, op_d};
                end else begin
                    word_d = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                              bus.in_rd, op_d};
                end
            end
            3'd2: begin
                op_d   = 7'b0000011;
                word_d = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, op_d};
            end
            3'd3: begin
                op_d   = 7'b0100011;
                word_d = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_imm[4:0], op_d};
            end
            3'd4: begin
                op_d   = 7'b1100011;
                word_d = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                          bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], op_d};
            end
            3'd5: begin
                op_d   = 7'b1101111;
                word_d = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                          bus.in_imm[19:12], bus.in_rd, op_d};
            end
            3'd6: begin
                op_d   = 7'b0110111;
                word_d = {bus.in_imm[31:12], bus.in_rd, op_d};
            end
            default: begin
                op_d   = 7'b0010111;
                word_d = {bus.in_imm[31:12], bus.in_rd, op_d};
            end
        endcase
    end

    // Session FSM with registered handshake, write port and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            count_q <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACTIVE;
                        ready_q <= 1'b1;
                        ptr_q   <= '0;
                        count_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (bus.in_valid && ready_q) begin
                        we_q    <= 1'b1;
                        addr_q  <= ptr_q;
                        wdata_q <= word_d;
                        ptr_q   <= ptr_q + 1'b1;
                        count_q <= count_q + 1'b1;
                        if (bus.in_last) begin
                            state_q <= DONE;
                            ready_q <= 1'b0;
                        end else if (ptr_q == PTR_LAST) begin
                            // Memory is full but the source still has more
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.count     = count_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a full-size instance (ADDR_W=8) for encoding,
// handshake and reset scenarios, and a small instance (ADDR_W=2) for the
// memory-full case. Expected {addr, word} pairs are queued when a bundle is
// accepted and popped when mem_we is seen.
module tb_instr_encoder;
    logic       clk;
    logic       rst;
    logic       start;
    logic       start_s;
    logic [1:0] state_m;
    logic [1:0] state_s;

    instr_encoder_if #(.ADDR_W(8)) bus ();
    instr_encoder_if #(.ADDR_W(2)) sbus ();

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus.slave), .state_o(state_m)
    );
    instr_encoder #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .bus(sbus.slave), .state_o(state_s)
    );

    int passed = 0;
    int total  = 0;
    int we_cnt = 0;
    int we_cnt_s = 0;

    logic [39:0] exp_q[$];
    logic [33:0] exp_s_q[$];
    logic [7:0]  exp_ptr;
    logic [1:0]  exp_ptr_s;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference encoder ----------------
    function automatic logic [31:0] model(input logic [2:0] fmt, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic b5,
                                          input logic [31:0] imm);
        logic [31:0] w;
        w = 32'h0;
        case (fmt)
            3'd0: begin
                w[6:0] = 7'h33; w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1;
                w[24:20] = rs2; w[30] = b5;
            end
            3'd1: begin
                w[6:0] = 7'h13; w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    w[24:20] = imm[4:0]; w[30] = b5;
                end else begin
                    w[31:20] = imm[11:0];
                end
            end
            3'd2: begin
                w[6:0] = 7'h03; w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1;
                w[31:20] = imm[11:0];
            end
            3'd3: begin
                w[6:0] = 7'h23; w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = rs1;
                w[24:20] = rs2; w[31:25] = imm[11:5];
            end
            3'd4: begin
                w[6:0] = 7'h63; w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3;
                w[19:15] = rs1; w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12];
            end
            3'd5: begin
                w[6:0] = 7'h6F; w[11:7] = rd; w[19:12] = imm[19:12]; w[20] = imm[11];
                w[30:21] = imm[10:1]; w[31] = imm[20];
            end
            3'd6: begin
                w[6:0] = 7'h37; w[11:7] = rd; w[31:12] = imm[31:12];
            end
            default: begin
                w[6:0] = 7'h17; w[11:7] = rd; w[31:12] = imm[31:12];
            end
        endcase
        return w;
    endfunction

    // ---------------- scoreboards (sample on falling edge) ----------------
    always @(negedge clk) begin
        if (!rst && bus.mem_we === 1'b1) begin
            logic [39:0] e;
            we_cnt = we_cnt + 1;
            total = total + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL wr_unexpected: got addr=%0d data=%08h, required no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== e)
                    $display("FAIL wr_data: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             bus.mem_addr, bus.mem_wdata, e[39:32], e[31:0]);
                else passed = passed + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && sbus.mem_we === 1'b1) begin
            logic [33:0] e;
            we_cnt_s = we_cnt_s + 1;
            total = total + 1;
            if (exp_s_q.size() == 0) begin
                $display("FAIL s_wr_unexpected: got addr=%0d data=%08h, required no write",
                         sbus.mem_addr, sbus.mem_wdata);
            end else begin
                e = exp_s_q.pop_front();
                if ({sbus.mem_addr, sbus.mem_wdata} !== e)
                    $display("FAIL s_wr_data: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             sbus.mem_addr, sbus.mem_wdata, e[33:32], e[31:0]);
                else passed = passed + 1;
            end
        end
    end

    // ---------------- driver tasks (entered just after a falling edge) ----------------
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        exp_ptr = 8'd0;
        total = total + 1;
        if (bus.in_ready !== 1'b1 || bus.count !== 9'd0 || bus.err !== 1'b0 || state_m !== 2'd1)
            $display("FAIL start: got ready=%b count=%0d err=%b state=%0d, required 1 0 0 1",
                     bus.in_ready, bus.count, bus.err, state_m);
        else passed = passed + 1;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic b5,
                        input logic [31:0] imm, input logic last, input logic [31:0] word);
        bit acc;
        acc = 0;
        bus.in_fmt = fmt; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_funct3 = f3; bus.in_funct7b5 = b5; bus.in_imm = imm; bus.in_last = last;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (bus.in_ready === 1'b1) begin
                exp_q.push_back({exp_ptr, word});
                exp_ptr = exp_ptr + 8'd1;
                acc = 1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        total = total + 1;
        if (!acc) $display("FAIL accept: got no acceptance in 20 cycles, required acceptance");
        else passed = passed + 1;
    endtask

    task automatic send_rand(input logic last);
        logic [2:0]  fmt;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        b5;
        logic [31:0] imm;
        fmt = 3'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31)); f3 = 3'($urandom_range(0, 7));
        b5 = 1'($urandom_range(0, 1)); imm = $urandom;
        send(fmt, rd, rs1, rs2, f3, b5, imm, last, model(fmt, rd, rs1, rs2, f3, b5, imm));
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.done === 1'b1) seen = 1;
            else @(negedge clk);
        end
        total = total + 1;
        if (!seen) $display("FAIL %s_done: got no done pulse in 10 cycles, required pulse", name);
        else passed = passed + 1;
        @(negedge clk);
        total = total + 1;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: got %0d writes missing, required 0", name, exp_q.size());
        else passed = passed + 1;
    endtask

    task automatic send_s(input logic [4:0] rd, input logic [31:0] imm, input int bound,
                          output bit acc);
        acc = 0;
        sbus.in_fmt = 3'd6; sbus.in_rd = rd; sbus.in_rs1 = 5'd0; sbus.in_rs2 = 5'd0;
        sbus.in_funct3 = 3'd0; sbus.in_funct7b5 = 1'b0; sbus.in_imm = imm;
        sbus.in_last = 1'b0; sbus.in_valid = 1'b1;
        for (int i = 0; i < bound && !acc; i++) begin
            if (sbus.in_ready === 1'b1) begin
                exp_s_q.push_back({exp_ptr_s, model(3'd6, rd, 5'd0, 5'd0, 3'd0, 1'b0, imm)});
                exp_ptr_s = exp_ptr_s + 2'd1;
                acc = 1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        sbus.in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        total = total + 1;
        if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'd0 ||
            bus.mem_wdata !== 32'd0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
            bus.count !== 9'd0 || state_m !== 2'd0)
            $display("FAIL reset: got rdy=%b we=%b addr=%0d wd=%08h done=%b err=%b cnt=%0d st=%0d, required all 0",
                     bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.done,
                     bus.err, bus.count, state_m);
        else passed = passed + 1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total = total + 1;
        if (bus.in_ready !== 1'b0) $display("FAIL idle_ready: got %b, required 0", bus.in_ready);
        else passed = passed + 1;
    endtask

    task automatic test_r_pair();
        do_start();
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0, 32'h002081B3);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b1, 32'h402081B3);
        total = total + 1;
        if (bus.count !== 9'd2 || bus.done !== 1'b0)
            $display("FAIL r_pair_count: got count=%0d done=%b, required 2 0", bus.count, bus.done);
        else passed = passed + 1;
        @(negedge clk);
        total = total + 1;
        if (bus.done !== 1'b1 || bus.in_ready !== 1'b0)
            $display("FAIL r_pair_done: got done=%b ready=%b, required 1 0", bus.done, bus.in_ready);
        else passed = passed + 1;
        @(negedge clk);
        total = total + 1;
        if (bus.done !== 1'b0 || state_m !== 2'd0 || exp_q.size() != 0)
            $display("FAIL r_pair_end: got done=%b state=%0d pending=%0d, required 0 0 0",
                     bus.done, state_m, exp_q.size());
        else passed = passed + 1;
    endtask

    task automatic test_load_store_shift();
        do_start();
        send(3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 32'd8, 1'b0, 32'h00812283);
        send(3'd3, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 32'd12, 1'b0, 32'h00512623);
        send(3'd1, 5'd4, 5'd4, 5'd0, 3'd5, 1'b1, 32'd3, 1'b1, 32'h40325213);
        wait_done("ldst");
    endtask

    task automatic test_ctrl_upper();
        do_start();
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'hFE208EE3);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b0, 32'h008000EF);
        send(3'd6, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 1'b0, 32'h123453B7);
        send(3'd7, 5'd9, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E000,
             1'b1, model(3'd7, 5'd9, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E000));
        wait_done("ctrl");
    endtask

    task automatic test_backpressure();
        do_start();
        we_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            send_rand(n == 9);
        end
        total = total + 1;
        if (bus.count !== 9'd10)
            $display("FAIL bp_count: got %0d, required 10", bus.count);
        else passed = passed + 1;
        wait_done("bp");
        total = total + 1;
        if (we_cnt != 10) $display("FAIL bp_writes: got %0d, required 10", we_cnt);
        else passed = passed + 1;
    endtask

    task automatic test_overflow();
        bit acc;
        start_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        exp_ptr_s = 2'd0;
        we_cnt_s = 0;
        for (int n = 0; n < 4; n++) begin
            send_s(5'(n + 1), $urandom, 20, acc);
            total = total + 1;
            if (!acc) $display("FAIL ovf_accept: bundle %0d got not accepted, required accepted", n);
            else passed = passed + 1;
        end
        total = total + 1;
        if (sbus.err !== 1'b1 || sbus.count !== 3'd4 || sbus.in_ready !== 1'b0)
            $display("FAIL ovf_err: got err=%b count=%0d ready=%b, required 1 4 0",
                     sbus.err, sbus.count, sbus.in_ready);
        else passed = passed + 1;
        @(negedge clk);
        total = total + 1;
        if (sbus.done !== 1'b1) $display("FAIL ovf_done: got %b, required 1", sbus.done);
        else passed = passed + 1;
        send_s(5'd31, 32'h5555_5000, 5, acc);
        total = total + 1;
        if (acc || we_cnt_s != 4)
            $display("FAIL ovf_fifth: got accepted=%0d writes=%0d, required 0 4", acc, we_cnt_s);
        else passed = passed + 1;
        start_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        total = total + 1;
        if (sbus.err !== 1'b0 || sbus.count !== 3'd0 || sbus.in_ready !== 1'b1)
            $display("FAIL ovf_restart: got err=%b count=%0d ready=%b, required 0 0 1",
                     sbus.err, sbus.count, sbus.in_ready);
        else passed = passed + 1;
    endtask

    task automatic test_reset_mid();
        do_start();
        send_rand(1'b0);
        total = total + 1;
        if (bus.mem_we !== 1'b1) $display("FAIL mid_we: got %b, required 1", bus.mem_we);
        else passed = passed + 1;
        #2 rst = 1'b1;
        #1;
        total = total + 1;
        if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0 || bus.mem_addr !== 8'd0 ||
            bus.mem_wdata !== 32'd0 || bus.count !== 9'd0 || bus.err !== 1'b0 ||
            bus.done !== 1'b0 || state_m !== 2'd0)
            $display("FAIL mid_reset: got we=%b rdy=%b addr=%0d wd=%08h cnt=%0d err=%b done=%b st=%0d, required all 0",
                     bus.mem_we, bus.in_ready, bus.mem_addr, bus.mem_wdata, bus.count,
                     bus.err, bus.done, state_m);
        else passed = passed + 1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        send_rand(1'b1);
        wait_done("mid");
    endtask

    // ---------------- sequence ----------------
    initial begin
        start = 1'b0; start_s = 1'b0;
        bus.in_valid = 1'b0; bus.in_fmt = 3'd0; bus.in_rd = 5'd0; bus.in_rs1 = 5'd0;
        bus.in_rs2 = 5'd0; bus.in_funct3 = 3'd0; bus.in_funct7b5 = 1'b0;
        bus.in_imm = 32'd0; bus.in_last = 1'b0;
        sbus.in_valid = 1'b0; sbus.in_fmt = 3'd0; sbus.in_rd = 5'd0; sbus.in_rs1 = 5'd0;
        sbus.in_rs2 = 5'd0; sbus.in_funct3 = 3'd0; sbus.in_funct7b5 = 1'b0;
        sbus.in_imm = 32'd0; sbus.in_last = 1'b0;
        exp_ptr = 8'd0; exp_ptr_s = 2'd0;

        test_reset();
        test_r_pair();
        test_load_store_shift();
        test_ctrl_upper();
        test_backpressure();
        test_overflow();
        test_reset_mid();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program loader: accepts decoded instruction fields (format, registers, funct bits, immediate) over a valid/ready stream, packs each into a 32-bit RV32I instruction word and writes it sequentially into instruction memory. It is the producer side of the instruction word consumed by `control`. It sits between the test/boot source and the instruction-memory write port.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; the memory depth is 2^ADDR_W words.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: arms a load session at word address 0. Honoured only in IDLE.
- `in_valid` input, 1 bit: the field bundle is valid.
- `in_ready` output, 1 bit: the encoder can accept a bundle.
- `in_fmt` input, 3 bits: format select. 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 LUI, 7 AUIPC.
- `in_rd`, `in_rs1`, `in_rs2` inputs, 5 bits each: register indices.
- `in_funct3` input, 3 bits: the funct3 field.
- `in_funct7b5` input, 1 bit: instruction bit 30. Used for SUB/SRA/SRAI.
- `in_imm` input, 32 bits: the immediate, already byte-offset and sign-extended.
- `in_last` input, 1 bit: marks the final bundle of the session.
- `mem_we` output, 1 bit: instruction-memory write strobe.
- `mem_addr` output, ADDR_W bits: word address.
- `mem_wdata` output, 32 bits: the encoded instruction.
- `done` output, 1 bit: one-cycle pulse at the end of a session.
- `err` output, 1 bit: sticky overflow flag; the memory filled before `in_last` arrived.
- `count` output, ADDR_W+1 bits: number of words written in the current session.

## Operation
- **Opcodes.** Bits [6:0] by format: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, LUI 0110111, AUIPC 0010111.
- **Field packing.** Any field not used by a format is driven to 0.
  - R: {0,funct7b5,00000, rs2, rs1, funct3, rd, op}.
  - I-ALU / LOAD: {imm[11:0], rs1, funct3, rd, op}.
  - I-ALU with funct3 001 or 101 (shifts): bits[31:25] = {0,funct7b5,00000} and bits[24:20] = imm[4:0].
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}. imm[0] is ignored.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}. imm[0] is ignored.
  - LUI / AUIPC: {imm[31:12], rd, op}.
- **FSM states: IDLE, ACTIVE, DONE.**
  - IDLE:
    - `in_ready` is 0.
    - `start` moves the FSM to ACTIVE, clears the address pointer, `count` and `err`.
  - ACTIVE:
    - `in_ready` is 1.
    - A bundle is accepted on any edge where `in_valid` and `in_ready` are both 1. The pointer and `count` then increment.
    - Accepting with `in_last` = 1 moves the FSM to DONE.
    - Accepting at pointer 2^ADDR_W-1 with `in_last` = 0 moves the FSM to DONE and sets `err`.
    - `start` is ignored.
  - DONE:
    - `in_ready` is 0.
    - `done` pulses high for one cycle.
    - The FSM moves to IDLE on the next edge.
- The pointer wraps to 0 only through a new `start`. It never wraps inside a session.
- Reset while mid-session aborts the session: all outputs clear and the state goes to IDLE. Words already written remain in memory.

## Timing
- **Reset values:** `in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `done`, `err` and `count` are all 0, and the state is IDLE. They take these values immediately on `rst` assertion, with no clock required.
- **Write latency:** `mem_we`, `mem_addr` and `mem_wdata` are registered. For a bundle accepted at edge E, they are valid during the cycle following E, and `mem_we` is high for exactly that one cycle.
- **Throughput:** one bundle per cycle; back-to-back writes have consecutive addresses.
- `count` updates at the acceptance edge, so it always equals the number of `mem_we` pulses issued or currently in flight.
- **Start latency:** `start` sampled at edge S gives `in_ready` = 1 during the cycle after S.
- **End of session:** for the last acceptance at edge E, the final `mem_we` is in cycle E+1 and `done` is high during cycle E+2. `err`, if set, is visible from cycle E+1.
- A bundle presented while `in_ready` = 0 is not consumed. The source must hold it.

## Test plan
- **R-type pair:** start, then R {rd=3, rs1=1, rs2=2, f3=0, b5=0} followed by the same bundle with b5=1 and in_last -> writes 0x002081B3 at address 0 and 0x402081B3 at address 1, `count` = 2, `done` one cycle later.
- **Load/store/shift:**
  - LOAD {rd=5, rs1=2, f3=2, imm=8} -> 0x00812283.
  - STORE {rs1=2, rs2=5, f3=2, imm=12} -> 0x00512623.
  - I-ALU {rd=4, rs1=4, f3=5, b5=1, imm=3} -> 0x40325213.
- **Control flow and upper immediates:**
  - BRANCH {rs1=1, rs2=2, f3=0, imm=-4} -> 0xFE208EE3.
  - JAL {rd=1, imm=8} -> 0x008000EF.
  - LUI {rd=7, imm=0x12345000} -> 0x123453B7.
- **Backpressure:** toggle `in_valid` randomly with 10 bundles -> exactly 10 `mem_we` pulses at addresses 0 to 9. No write appears while `in_ready` = 0 and none is duplicated.
- **Overflow:** with ADDR_W=2, send 5 bundles without `in_last` -> 4 writes at addresses 0 to 3, then `err` = 1 and `done` pulses. The 5th bundle is not accepted. A following `start` clears `err`.
- **Reset mid-session:** assert `rst` while `mem_we` = 1 -> `mem_we` drops asynchronously, all outputs are 0 and the FSM is in IDLE. A new `start` restarts the session at address 0.
